// File: rtl/am_inserter.sv
// TX alignment-marker inserter: replaces one block slot on every PCS lane with
// that lane's AM (carrying the running BIP) once per AM_PERIOD blocks.
module am_inserter #(
  parameter int N_LANES   = 20,
  parameter int NB_DATA   = 66,
  parameter int AM_PERIOD = 16384,
  parameter int NB_PERIOD = $clog2(AM_PERIOD),
  parameter logic [N_LANES*24-1:0] AM_CODES = {
    24'hE5F0C0, 24'h2A665F, 24'hB7D6AD, 24'h4C31C4, 24'hCD3635,
    24'hCAC783, 24'hBDF81A, 24'hB2B95C, 24'h5591B9, 24'h996CFD,
    24'hFBC968, 24'h7624A0, 24'h66457B, 24'h264A9A, 24'hC214DD,
    24'h0907F5, 24'h7B954D, 24'hE84B59, 24'h8E719D, 24'h2168C1}
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic [N_LANES*NB_DATA-1:0]   i_data,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [N_LANES*NB_DATA-1:0]   o_data,
  output logic                         o_am_insert
);

  typedef enum logic {AM_SLOT = 1'b0, DATA_SLOT = 1'b1} state_e;

  localparam logic [NB_PERIOD-1:0] CNT_LAST = NB_PERIOD'(AM_PERIOD - 1);
  localparam logic [NB_PERIOD-1:0] CNT_ONE  = NB_PERIOD'(1);

  state_e                        state_q, state_d;
  logic [NB_PERIOD-1:0]          cnt_q, cnt_d;
  logic [N_LANES-1:0][7:0]       bip_q, bip_d;
  logic [N_LANES*NB_DATA-1:0]    data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          am_q, am_d;

  // Sync header bits fold into columns 3 and 4 of the interleaved parity.
  function automatic logic [7:0] bip_of(input logic [65:0] blk);
    logic [7:0] p;
    p = blk[9:2] ^ blk[17:10] ^ blk[25:18] ^ blk[33:26]
      ^ blk[41:34] ^ blk[49:42] ^ blk[57:50] ^ blk[65:58];
    p[3] = p[3] ^ blk[0];
    p[4] = p[4] ^ blk[1];
    return p;
  endfunction

  function automatic logic [65:0] am_block(input logic [23:0] code, input logic [7:0] bip);
    return {~bip, ~code[23:16], ~code[15:8], ~code[7:0],
            bip, code[23:16], code[15:8], code[7:0], 2'b01};
  endfunction

  assign o_ready     = (state_q == DATA_SLOT) && i_enable;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_am_insert = am_q;

  // Next-state, period count, BIP accumulation and output block selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bip_d   = bip_q;
    data_d  = data_q;
    valid_d = 1'b0;
    am_d    = 1'b0;
    if (i_enable) begin
      case (state_q)
        AM_SLOT: begin
          for (int k = 0; k < N_LANES; k++) begin
            data_d[k*NB_DATA +: NB_DATA] = am_block(AM_CODES[k*24 +: 24], bip_q[k]);
            bip_d[k] = bip_of(data_d[k*NB_DATA +: NB_DATA]);
          end
          valid_d = 1'b1;
          am_d    = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = DATA_SLOT;
        end
        DATA_SLOT: begin
          if (i_valid) begin
            data_d  = i_data;
            valid_d = 1'b1;
            for (int k = 0; k < N_LANES; k++) begin
              bip_d[k] = bip_q[k] ^ bip_of(i_data[k*NB_DATA +: NB_DATA]);
            end
            // Last data slot of the period hands over to the AM slot.
            if (cnt_q == CNT_LAST) begin
              state_d = AM_SLOT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = AM_SLOT;
        end
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= AM_SLOT;
      cnt_q   <= '0;
      bip_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bip_q   <= bip_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      am_q    <= am_d;
    end
  end

endmodule

// File: doc/am_inserter.md
Name: am_inserter

Overview:
- TX-side alignment-marker inserter for the 100GbE PCS; the transmit counterpart of the RX deskew path.
- Takes N_LANES scrambled 66-bit blocks per clock, one per PCS lane, after block distribution.
- Periodically replaces one block slot on all lanes at once with the per-lane alignment marker (AM), including the running BIP, so the receiver can lock, deskew and reorder lanes.
- Upstream is throttled with a ready handshake during AM slots.

Parameters:
- N_LANES, 20, number of PCS lanes.
- NB_DATA, 66, bits per block.
- AM_PERIOD, 16384, blocks per lane per AM period, including the AM slot; must be ≥2.
- NB_PERIOD, $clog2(AM_PERIOD), width of the period counter.
- AM_CODES, IEEE 802.3 Table 82-2 values, N_LANES*24 bits; lane k = AM_CODES[k*24 +: 24] = {M2,M1,M0}. Lane 0 is M0=C1, M1=68, M2=21; lane 1 is M0=9D, M1=71, M2=8E.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_enable  in  1  global enable; when low, the block is frozen.
- i_valid  in  1  i_data holds a valid block on every lane.
- i_data  in  N_LANES*NB_DATA  lane k = [k*NB_DATA +: NB_DATA]; bit 0 is the first transmitted bit.
- o_ready  out  1  block accepts i_data this cycle (combinational).
- o_valid  out  1  o_data valid.
- o_data  out  N_LANES*NB_DATA  same lane and bit layout as i_data.
- o_am_insert  out  1  o_data carries AMs on all lanes.

Behaviour:
- Reset (async, i_reset=0):
  - o_data=0, o_valid=0, o_am_insert=0.
  - State=AM_SLOT, period counter=0, all per-lane BIP accumulators=0.
- FSM, two states:
  - AM_SLOT: o_ready=0.
  - DATA_SLOT: o_ready=i_enable.
- i_enable=0:
  - o_ready=0 and o_valid=0 on the next edge.
  - Counter, state, BIP and o_data hold.
- AM_SLOT with i_enable=1:
  - Next edge emits the AM on every lane, independent of i_valid.
  - o_valid=1, o_am_insert=1.
  - Counter<=1; state<=DATA_SLOT.
- DATA_SLOT with i_enable=1:
  - Accept when i_valid=1. Next edge: o_data<=i_data, o_valid=1, o_am_insert=0, counter+1.
  - When the counter reaches AM_PERIOD-1 accepted blocks, state<=AM_SLOT.
  - i_valid=0: o_valid=0 next edge; counter and BIP unchanged. Gaps do not shorten the period.
- Latency: exactly 1 cycle from accept to o_data; output is registered.
- Simultaneous events:
  - Reset dominates everything.
  - The first emitted block after reset release is always an AM.
- AM block layout per lane, bit indices:
  - Bit 0 = 1, bit 1 = 0 (control sync header).
  - [9:2]=M0, [17:10]=M1, [25:18]=M2, [33:26]=BIP3.
  - [41:34]=M4=~M0, [49:42]=M5=~M1, [57:50]=M6=~M2, [65:58]=BIP7=~BIP3.
- BIP, per lane, 8 bits:
  - BIP3[j] = XOR over every emitted block of bits p in 2..65 with (p-2) mod 8 == j.
  - Additionally, bit 0 folds into BIP3[3] and bit 1 folds into BIP3[4].
  - Scope: from the previous AM (inclusive, with its BIP fields as transmitted) up to, not including, the current AM.
  - On AM emission, the accumulator <= parity of the emitted AM itself.
  - Otherwise it accumulates each accepted data block.
- AMs are not scrambled; data passes bit-exact, with no inspection of sync headers.
- Counter wraps only through AM_SLOT; it never exceeds AM_PERIOD-1.

Test Plan:
1. AM_PERIOD=4, reset then release, i_enable=1, i_valid=1, data blocks all-zero except bit1=1 -> first o_valid cycle has o_am_insert=1.
   - Lane 0 = AM with M0=C1, M1=68, M2=21, BIP3=00, BIP7=FF.
   - Lane 1 M0=9D.
   - o_ready=0 during that slot.
2. Same run, continued -> 3 data cycles echo i_data with 1-cycle latency, then an AM.
   - o_ready low exactly 1 cycle in 4.
   - o_am_insert high every 4th o_valid cycle.
3. BIP check from scenario 1 -> second AM, lane 0: BIP3=18, BIP7=E7 (first AM contributes 08, three data headers toggle bit 4).
4. Drop i_valid for 2 cycles mid DATA_SLOT -> o_valid=0 for those 2 cycles.
   - The AM still appears only after 3 accepted data blocks.
   - BIP is unaffected by the gap.
5. Drop i_enable for 3 cycles in DATA_SLOT -> o_ready=0, o_valid=0, o_data held; resume continues the same period count.
6. Assert i_reset=0 mid-period -> outputs 0 immediately (async).
   - After release, the first block is an AM with BIP3=00 on all lanes.
